// File: rtl/rx_ctrl.sv
// Receive-path controller: sequences rxshift, validates start/parity/stop,
// buffers good bytes in a first-word-fall-through FIFO and keeps sticky error flags.
module rx_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0,
  parameter int IDLE_BITS  = 2
) (
  input  logic                          i_Pclk,
  input  logic                          i_Reset,
  input  logic                          i_Bclk,
  input  logic                          i_Rx_Enable,
  input  logic                          i_Rx_Serial,
  output logic                          o_Shift_Enable,
  input  logic [10:0]                   i_Frame,
  input  logic                          i_Frame_Done,
  input  logic                          i_Rd,
  output logic [7:0]                    o_Rd_Data,
  output logic                          o_Empty,
  output logic                          o_Full,
  output logic [$clog2(FIFO_DEPTH):0]   o_Count,
  output logic                          o_Parity_Err,
  output logic                          o_Frame_Err,
  output logic                          o_Overrun,
  input  logic                          i_Clr_Err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CHECK, S_RECOVER} state_t;

  state_t          state_reg, state_next;
  logic            bclk_reg, bclk_prev_reg;
  logic            done_reg, done_prev_reg;
  logic [10:0]     frame_reg;
  logic [3:0]      idle_cnt_reg;
  logic [7:0]      mem_reg [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            parity_err_reg, frame_err_reg, overrun_reg;

  logic bclk_rise, done_rise;
  logic frame_bad, parity_bad, fifo_full, fifo_empty;
  logic in_check, set_frame, set_parity, set_overrun, push, pop;

  assign bclk_rise  = bclk_reg & ~bclk_prev_reg;
  assign done_rise  = done_reg & ~done_prev_reg;
  assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);

  assign frame_bad  = frame_reg[0] | ~frame_reg[10];
  assign parity_bad = (^frame_reg[9:1]) != (PARITY_ODD != 0);
  assign in_check   = (state_reg == S_CHECK);

  assign set_frame   = in_check & frame_bad;
  assign set_parity  = in_check & ~frame_bad & parity_bad;
  // A read in the CHECK cycle frees a slot, so a full FIFO can still accept the byte.
  assign set_overrun = in_check & ~frame_bad & ~parity_bad & fifo_full & ~i_Rd;
  assign push        = in_check & ~frame_bad & ~parity_bad & (~fifo_full | i_Rd);
  assign pop         = i_Rd & ~fifo_empty;

  always_ff @(posedge i_Pclk or posedge i_Reset) begin
    if (i_Reset) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (i_Rx_Enable) state_next = S_ARM;
      S_ARM: begin
        if (!i_Rx_Enable)   state_next = S_IDLE;
        else if (done_rise) state_next = S_CHECK;
      end
      S_CHECK:   state_next = frame_bad ? S_RECOVER : S_IDLE;
      S_RECOVER: begin
        if (!i_Rx_Enable)                      state_next = S_IDLE;
        else if (idle_cnt_reg == 4'(IDLE_BITS)) state_next = S_IDLE;
      end
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_Shift_Enable = 1'b0;
    if (state_reg == S_ARM) o_Shift_Enable = 1'b1;
  end

  always_ff @(posedge i_Pclk or posedge i_Reset) begin
    if (i_Reset) begin
      bclk_reg      <= 1'b0;
      bclk_prev_reg <= 1'b0;
      done_reg      <= 1'b0;
      done_prev_reg <= 1'b0;
      frame_reg     <= '0;
      idle_cnt_reg  <= '0;
    end else begin
      bclk_reg      <= i_Bclk;
      bclk_prev_reg <= bclk_reg;
      done_reg      <= i_Frame_Done;
      done_prev_reg <= done_reg;
      if (state_reg == S_ARM && done_rise) frame_reg <= i_Frame;
      // Idle counter restarts whenever the line is seen low during recovery.
      if (in_check) begin
        idle_cnt_reg <= '0;
      end else if (state_reg == S_RECOVER) begin
        if (!i_Rx_Serial)                         idle_cnt_reg <= '0;
        else if (bclk_rise && idle_cnt_reg != 4'hF) idle_cnt_reg <= idle_cnt_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge i_Pclk or posedge i_Reset) begin
    if (i_Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= 8'h00;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= frame_reg[8:1];
        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge i_Pclk or posedge i_Reset) begin
    if (i_Reset) begin
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      parity_err_reg <= (parity_err_reg & ~i_Clr_Err) | set_parity;
      frame_err_reg  <= (frame_err_reg  & ~i_Clr_Err) | set_frame;
      overrun_reg    <= (overrun_reg    & ~i_Clr_Err) | set_overrun;
    end
  end

  assign o_Rd_Data    = mem_reg[rd_ptr_reg];
  assign o_Empty      = fifo_empty;
  assign o_Full       = fifo_full;
  assign o_Count      = count_reg;
  assign o_Parity_Err = parity_err_reg;
  assign o_Frame_Err  = frame_err_reg;
  assign o_Overrun    = overrun_reg;

endmodule

// File: tb/tb_rx_ctrl.sv
// Scoreboard bench for rx_ctrl: a behavioural rxshift stand-in delivers frames,
// expected bytes are queued and a monitor checks every pop.
module tb_rx_ctrl;

  logic        i_Pclk = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_Bclk = 1'b0;
  logic        i_Rx_Enable = 1'b0;
  logic        i_Rx_Serial = 1'b1;
  logic        o_Shift_Enable;
  logic [10:0] i_Frame = '0;
  logic        i_Frame_Done = 1'b0;
  logic        i_Rd = 1'b0;
  logic [7:0]  o_Rd_Data;
  logic        o_Empty, o_Full;
  logic [2:0]  o_Count;
  logic        o_Parity_Err, o_Frame_Err, o_Overrun;
  logic        i_Clr_Err = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  rx_ctrl #(.FIFO_DEPTH(4), .PARITY_ODD(0), .IDLE_BITS(2)) dut (
    .i_Pclk(i_Pclk), .i_Reset(i_Reset), .i_Bclk(i_Bclk),
    .i_Rx_Enable(i_Rx_Enable), .i_Rx_Serial(i_Rx_Serial),
    .o_Shift_Enable(o_Shift_Enable), .i_Frame(i_Frame),
    .i_Frame_Done(i_Frame_Done), .i_Rd(i_Rd), .o_Rd_Data(o_Rd_Data),
    .o_Empty(o_Empty), .o_Full(o_Full), .o_Count(o_Count),
    .o_Parity_Err(o_Parity_Err), .o_Frame_Err(o_Frame_Err),
    .o_Overrun(o_Overrun), .i_Clr_Err(i_Clr_Err)
  );

  always #5 i_Pclk = ~i_Pclk;

  // Free-running bit clock, 8 system clocks per bit, edges between system clock edges.
  always begin
    #60 i_Bclk = 1'b1;
    #20 i_Bclk = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_Pclk) begin
    if (!i_Reset && i_Rd && !o_Empty) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 32'd1, 32'd0);
      end else begin
        chk("pop_data", {24'd0, o_Rd_Data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_shift(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge i_Pclk);
      if (o_Shift_Enable) break;
    end
    chk(name, {31'd0, o_Shift_Enable}, 32'd1);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge i_Pclk);
    #1;
  endtask

  // Delivers one frame; returns during cycle T+4 where T is the first Done cycle.
  task automatic send_frame(input logic [10:0] frame, input bit rd_in_check, input bit timing);
    logic sh [5];
    logic [2:0] cn [5];
    wait_shift("arm_before_frame", 40);
    @(posedge i_Pclk); #1;
    i_Frame      = frame;
    i_Frame_Done = 1'b1;
    @(negedge i_Pclk);
    sh[0] = o_Shift_Enable; cn[0] = o_Count;
    for (int k = 1; k <= 4; k++) begin
      @(posedge i_Pclk); #1;
      if (k == 2 && rd_in_check) i_Rd = 1'b1;
      if (k == 3) begin
        i_Rd         = 1'b0;
        i_Frame_Done = 1'b0;
      end
      @(negedge i_Pclk);
      sh[k] = o_Shift_Enable; cn[k] = o_Count;
    end
    if (timing) begin
      chk("t_shift_T+1", {31'd0, sh[1]}, 32'd1);
      chk("t_shift_T+2", {31'd0, sh[2]}, 32'd0);
      chk("t_count_T+2", {29'd0, cn[2]}, 32'd0);
      chk("t_count_T+3", {29'd0, cn[3]}, 32'd1);
      chk("t_rearm_T+4", {31'd0, sh[4]}, 32'd1);
    end
  endtask

  task automatic pulse_rd();
    @(posedge i_Pclk); #1; i_Rd = 1'b1;
    @(posedge i_Pclk); #1; i_Rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge i_Pclk); #1; i_Clr_Err = 1'b1;
    @(posedge i_Pclk); #1; i_Clr_Err = 1'b0;
  endtask

  // Good frames for 0x01..0x06, even parity, hand-encoded {stop, parity, data, start}.
  logic [10:0] fill_frames [6] = '{11'b11000000010, 11'b11000000100, 11'b10000000110,
                                   11'b11000001000, 11'b10000001010, 11'b10000001100};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    @(negedge i_Pclk);
    chk("rst_empty", {31'd0, o_Empty}, 32'd1);
    chk("rst_full", {31'd0, o_Full}, 32'd0);
    chk("rst_count", {29'd0, o_Count}, 32'd0);
    chk("rst_data", {24'd0, o_Rd_Data}, 32'h00);
    chk("rst_shift", {31'd0, o_Shift_Enable}, 32'd0);
    chk("rst_flags", {29'd0, o_Parity_Err, o_Frame_Err, o_Overrun}, 32'd0);
    @(posedge i_Pclk); #1; i_Reset = 1'b0;
    cycles(2);
    chk("idle_disabled_shift", {31'd0, o_Shift_Enable}, 32'd0);

    // Good frame 0x8D with latency checks
    i_Rx_Enable = 1'b1;
    send_frame(11'b10100011010, 1'b0, 1'b1);
    exp_q.push_back(8'h8D);
    chk("good_empty", {31'd0, o_Empty}, 32'd0);
    chk("good_count", {29'd0, o_Count}, 32'd1);
    chk("good_head", {24'd0, o_Rd_Data}, 32'h8D);
    chk("good_flags", {29'd0, o_Parity_Err, o_Frame_Err, o_Overrun}, 32'd0);
    pulse_rd();
    @(negedge i_Pclk);
    chk("good_popped_empty", {31'd0, o_Empty}, 32'd1);

    // Parity error
    send_frame(11'b11100011010, 1'b0, 1'b0);
    chk("par_flag", {31'd0, o_Parity_Err}, 32'd1);
    chk("par_empty", {31'd0, o_Empty}, 32'd1);
    pulse_clr();
    @(negedge i_Pclk);
    chk("par_cleared", {31'd0, o_Parity_Err}, 32'd0);

    // Framing error, line held low, then released
    i_Rx_Serial = 1'b0;
    send_frame(11'b00100011010, 1'b0, 1'b0);
    chk("frm_flag", {31'd0, o_Frame_Err}, 32'd1);
    chk("frm_shift_low", {31'd0, o_Shift_Enable}, 32'd0);
    cycles(30);
    @(negedge i_Pclk);
    chk("frm_hold_while_low", {31'd0, o_Shift_Enable}, 32'd0);
    i_Rx_Serial = 1'b1;
    wait_shift("frm_rearm", 40);
    pulse_clr();
    send_frame(11'b10100011010, 1'b0, 1'b0);
    exp_q.push_back(8'h8D);
    chk("frm_next_count", {29'd0, o_Count}, 32'd1);
    chk("frm_flag_clear", {31'd0, o_Frame_Err}, 32'd0);
    pulse_rd();

    // Fill and overrun
    for (int i = 0; i < 5; i++) begin
      send_frame(fill_frames[i], 1'b0, 1'b0);
      if (i < 4) exp_q.push_back(8'(i + 1));
    end
    chk("ovr_full", {31'd0, o_Full}, 32'd1);
    chk("ovr_count", {29'd0, o_Count}, 32'd4);
    chk("ovr_flag", {31'd0, o_Overrun}, 32'd1);
    chk("ovr_head", {24'd0, o_Rd_Data}, 32'h01);
    pulse_clr();

    // Read in the CHECK cycle of a sixth frame while full
    send_frame(fill_frames[5], 1'b1, 1'b0);
    exp_q.push_back(8'h06);
    chk("rw_count", {29'd0, o_Count}, 32'd4);
    chk("rw_no_overrun", {31'd0, o_Overrun}, 32'd0);
    chk("rw_full", {31'd0, o_Full}, 32'd1);
    for (int i = 0; i < 4; i++) pulse_rd();
    @(negedge i_Pclk);
    chk("rw_drained", {31'd0, o_Empty}, 32'd1);
    chk("rw_queue_used", exp_q.size(), 32'd0);

    // Abort mid-frame
    wait_shift("abort_armed", 40);
    cycles(3);
    i_Rx_Enable = 1'b0;
    @(negedge i_Pclk);
    @(negedge i_Pclk);
    chk("abort_shift", {31'd0, o_Shift_Enable}, 32'd0);
    chk("abort_empty", {31'd0, o_Empty}, 32'd1);
    chk("abort_flags", {29'd0, o_Parity_Err, o_Frame_Err, o_Overrun}, 32'd0);
    @(posedge i_Pclk); #1; i_Rx_Enable = 1'b1;

    // Reset while armed with two entries queued and a flag set
    send_frame(11'b11100011010, 1'b0, 1'b0);
    send_frame(11'b11101000010, 1'b0, 1'b0);
    send_frame(11'b10001111000, 1'b0, 1'b0);
    chk("pre_rst_count", {29'd0, o_Count}, 32'd2);
    chk("pre_rst_head", {24'd0, o_Rd_Data}, 32'hA1);
    chk("pre_rst_parity", {31'd0, o_Parity_Err}, 32'd1);
    @(posedge i_Pclk); #3; i_Reset = 1'b1;
    #1;
    chk("arst_shift", {31'd0, o_Shift_Enable}, 32'd0);
    chk("arst_empty", {31'd0, o_Empty}, 32'd1);
    chk("arst_full", {31'd0, o_Full}, 32'd0);
    chk("arst_count", {29'd0, o_Count}, 32'd0);
    chk("arst_data", {24'd0, o_Rd_Data}, 32'h00);
    chk("arst_flags", {29'd0, o_Parity_Err, o_Frame_Err, o_Overrun}, 32'd0);
    @(posedge i_Pclk); #1; i_Reset = 1'b0;
    wait_shift("post_rst_rearm", 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_ctrl.md
# rx_ctrl

Receive-path controller for the USRT. Sequences the `rxshift` frame shifter via its enable and done signals, and validates each captured 11-bit frame: start, parity and stop bits. Good data bytes are buffered in a small first-word-fall-through FIFO for the host. Errors are reported as sticky flags, and the block resynchronises to the line after a framing error. It sits between `baudgen`/`rxshift` and the host register interface.

## Interface
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥2.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity, over the 8 data bits.
- `IDLE_BITS`, 2: consecutive high bit periods required on the line before re-arming after a framing error; range 1–15.
- `i_Pclk`  in  1  system clock; all logic is on its rising edge.
- `i_Reset`  in  1  asynchronous, active-high reset.
- `i_Bclk`  in  1  bit clock from `baudgen`. Sampled on `i_Pclk`; each rising edge marks one bit period.
- `i_Rx_Enable`  in  1  host receive enable.
- `i_Rx_Serial`  in  1  raw serial line, used only for idle detection.
- `o_Shift_Enable`  out  1  drives the `rxshift` `i_Enable` input.
- `i_Frame`  in  11  `rxshift` `o_Data`. Bit 0 = start, bits 8:1 = data (LSB first), bit 9 = parity, bit 10 = stop.
- `i_Frame_Done`  in  1  `rxshift` `o_Done`.
- `i_Rd`  in  1  pop the FIFO head.
- `o_Rd_Data`  out  8  FIFO head; valid while `o_Empty`=0.
- `o_Empty`  out  1  FIFO empty.
- `o_Full`  out  1  FIFO full.
- `o_Count`  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- `o_Parity_Err`  out  1  sticky: a frame was dropped for bad parity.
- `o_Frame_Err`  out  1  sticky: a frame was dropped for a bad start or stop bit.
- `o_Overrun`  out  1  sticky: a good frame was dropped because the FIFO was full.
- `i_Clr_Err`  in  1  synchronous clear of all three sticky flags.

## Operation
- Reset values: state IDLE, `o_Shift_Enable`=0, `o_Empty`=1, `o_Full`=0, `o_Count`=0, `o_Rd_Data`=8'h00, all error flags 0. Pointers and storage are cleared.
- Edge detection: `i_Bclk` and `i_Frame_Done` are registered once; a rise is current=1 and previous=0.
- States:
  - IDLE: `o_Shift_Enable`=0. Goes to ARM when `i_Rx_Enable`=1.
  - ARM: `o_Shift_Enable`=1. On a `i_Frame_Done` rise, latches `i_Frame`, drops `o_Shift_Enable` and goes to CHECK.
  - CHECK: evaluates one frame, then goes to IDLE (frame good or dropped) or RECOVER (framing error).
    - Framing error when start≠0 or stop≠1: sets `o_Frame_Err`; goes to RECOVER.
    - Otherwise, parity error when XOR(data, parity) ≠ `PARITY_ODD`: sets `o_Parity_Err`, drops the byte; goes to IDLE.
    - Otherwise, if the FIFO is full and `i_Rd`=0: sets `o_Overrun`, drops the new byte, keeps existing contents; goes to IDLE.
    - Otherwise, pushes the data byte; goes to IDLE.
  - RECOVER: `o_Shift_Enable`=0. A 4-bit counter increments on each `i_Bclk` rise while `i_Rx_Serial`=1 and clears on `i_Rx_Serial`=0. Counter reaching `IDLE_BITS` → IDLE.
- IDLE always holds `o_Shift_Enable` low for at least one `i_Pclk` cycle between frames, which re-arms `rxshift`.
- `i_Rx_Enable`=0 in ARM or RECOVER: abort. Goes to IDLE next cycle, `o_Shift_Enable`=0, the partial frame is discarded, and the FIFO and flags are untouched.
- FIFO behaviour:
  - `i_Rd` while empty is ignored.
  - Push and pop in the same cycle: both happen and `o_Count` is unchanged. This holds when full, so no overrun is raised.
  - Pointers wrap modulo `FIFO_DEPTH`.
- If `i_Clr_Err` and an error-set event occur in the same cycle, the set wins.

## Timing
- `i_Frame_Done` first sampled high at cycle T:
  - rise detected at T+1; `o_Shift_Enable` is 0 from T+2;
  - CHECK at T+2;
  - push, flag update, `o_Empty`/`o_Count` change visible at T+3.
- Pop: `o_Rd_Data` shows the next entry, and `o_Count` decrements, in the cycle after `i_Rd` is sampled.
- First re-arm after CHECK: `o_Shift_Enable` rises at T+4 if `i_Rx_Enable`=1.
- Reset asserted mid-frame forces all reset values immediately (asynchronous), with no partial push.

## Test plan
- Enable, then send frame 11'b10100011010 via `rxshift` → `o_Empty`=0, `o_Rd_Data`=8'h8D, `o_Count`=1, no flags. Pulse `i_Rd` → `o_Empty`=1.
- Send 11'b11100011010 (parity bit flipped) → `o_Parity_Err`=1, FIFO stays empty. Pulse `i_Clr_Err` → flag 0.
- Send 11'b00100011010 (stop=0) → `o_Frame_Err`=1, state RECOVER, `o_Shift_Enable`=0. Hold the line high for 2 bit periods → re-arms; the next valid frame 8'h8D is stored.
- Send 5 good frames (8'h01..8'h05) with no reads → `o_Full`=1, `o_Count`=4, `o_Overrun`=1, head=8'h01.
  - Then assert `i_Rd` in the CHECK cycle of a 6th frame (8'h06) → `o_Count` stays 4, no new overrun, tail=8'h06.
- Drop `i_Rx_Enable` halfway through a frame → `o_Shift_Enable`=0 within 2 cycles, nothing stored, no flags.
- Assert `i_Reset` in ARM with 2 entries queued → all outputs return to their reset values immediately.
